// File: rtl/arbitro_escrita_banco_pkg.sv
// Shared constants for the register-bank write arbiter: requester indices and
// the special register addresses seen by the writeback path.
package arbitro_escrita_banco_pkg;

   localparam int N_REQ_WB = 3;

   localparam int REQ_ULA = 0;
   localparam int REQ_MEM = 1;
   localparam int REQ_JAL = 2;

   localparam logic [2:0] REG_ZERO = 3'd0;
   localparam logic [2:0] REG_LINK = 3'd7;

endpackage

// File: rtl/arbitro_escrita_banco_seletor.sv
// Combinational round-robin selector: searches from the pointer upward,
// wrapping modulo N_REQ, and returns a one-hot grant plus the encoded winner.
module seletor_round_robin
   import arbitro_escrita_banco_pkg::*;
#(
   parameter int N_REQ       = N_REQ_WB,
   parameter int LARGURA_PTR = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [LARGURA_PTR-1:0] i_ponteiro,
   input  logic [N_REQ-1:0]       i_req,
   output logic [N_REQ-1:0]       o_grant,
   output logic [LARGURA_PTR-1:0] o_vencedor,
   output logic                   o_valido
);

   localparam logic [LARGURA_PTR:0] N_REQ_L = (LARGURA_PTR + 1)'(N_REQ);

   logic [LARGURA_PTR:0]   w_soma;
   logic [LARGURA_PTR-1:0] w_idx;

   // NOTE: every output and temporary gets a default before the loop, so no
   // path through this block leaves a value unassigned and no latch is inferred.
   always_comb begin
      o_grant    = '0;
      o_vencedor = '0;
      o_valido   = 1'b0;
      w_soma     = '0;
      w_idx      = '0;
      // Walk from the farthest offset back to the pointer; the nearest
      // requesting index is written last and therefore wins.
      for (int off = N_REQ - 1; off >= 0; off--) begin
         w_soma = {1'b0, i_ponteiro} + (LARGURA_PTR + 1)'(off);
         if (w_soma >= N_REQ_L) w_soma = w_soma - N_REQ_L;
         w_idx = w_soma[LARGURA_PTR-1:0];
         if (i_req[w_idx]) begin
            o_grant        = '0;
            o_grant[w_idx] = 1'b1;
            o_vencedor     = w_idx;
            o_valido       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arbitro_escrita_banco.sv
// Round-robin arbiter for the single write port of the register bank, with a
// one-cycle registered write stage and a per-register pending-write mask.
module arbitro_escrita_banco
   import arbitro_escrita_banco_pkg::*;
#(
   parameter int LARGURA_DADO = 16,
   parameter int LARGURA_END  = 3,
   parameter int N_REQ        = N_REQ_WB
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [N_REQ-1:0]                req,
   input  logic [N_REQ*LARGURA_END-1:0]    end_req,
   input  logic [N_REQ*LARGURA_DADO-1:0]   dado_req,
   input  logic                            bloqueio,
   output logic [N_REQ-1:0]                ack,
   output logic                            permisao_escrita,
   output logic [LARGURA_END-1:0]          endereco_regd,
   output logic [LARGURA_DADO-1:0]         dado_escrita,
   output logic [(2**LARGURA_END)-1:0]     pendente,
   output logic                            ocupado
);

   localparam int LARGURA_PTR = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [LARGURA_PTR-1:0]  r_ponteiro;
   logic                    r_permisao;
   logic [LARGURA_END-1:0]  r_endereco;
   logic [LARGURA_DADO-1:0] r_dado;

   logic [N_REQ-1:0]        w_grant;
   logic [LARGURA_PTR-1:0]  w_vencedor;
   logic                    w_valido;
   logic                    w_concede;
   logic                    w_escreve;
   logic [LARGURA_PTR-1:0]  w_ponteiro_prox;
   logic [LARGURA_END-1:0]  w_end_venc;
   logic [LARGURA_DADO-1:0] w_dado_venc;

   seletor_round_robin #(
      .N_REQ       (N_REQ),
      .LARGURA_PTR (LARGURA_PTR)
   ) u_seletor (
      .i_ponteiro (r_ponteiro),
      .i_req      (req),
      .o_grant    (w_grant),
      .o_vencedor (w_vencedor),
      .o_valido   (w_valido)
   );

   assign w_concede = reset & ~bloqueio & w_valido;
   assign ack       = w_concede ? w_grant : '0;

   always_comb begin
      w_end_venc  = '0;
      w_dado_venc = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_vencedor == LARGURA_PTR'(i)) begin
            w_end_venc  = end_req[i*LARGURA_END +: LARGURA_END];
            w_dado_venc = dado_req[i*LARGURA_DADO +: LARGURA_DADO];
         end
      end
   end

   // r0 is hard-wired to zero in the bank, so a grant to it releases the
   // requester without producing a write.
   assign w_escreve = w_concede && (w_end_venc != LARGURA_END'(REG_ZERO));

   assign w_ponteiro_prox = (w_vencedor == LARGURA_PTR'(N_REQ - 1)) ? '0
                                                                    : w_vencedor + 1'b1;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ponteiro <= '0;
         r_permisao <= 1'b0;
         r_endereco <= '0;
         r_dado     <= '0;
      end else begin
         r_permisao <= w_escreve;
         if (w_escreve) begin
            r_endereco <= w_end_venc;
            r_dado     <= w_dado_venc;
         end
         if (w_concede) r_ponteiro <= w_ponteiro_prox;
      end
   end

   assign permisao_escrita = r_permisao;
   assign endereco_regd    = r_endereco;
   assign dado_escrita     = r_dado;
   assign ocupado          = (|req) | r_permisao;

   always_comb begin
      pendente = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (req[i]) pendente[end_req[i*LARGURA_END +: LARGURA_END]] = 1'b1;
      end
      if (r_permisao) pendente[r_endereco] = 1'b1;
      pendente[0] = 1'b0;
   end

endmodule

// File: tb/tb_arbitro_escrita_banco.sv
// Self-checking bench for arbitro_escrita_banco: a reference model predicts
// grants and pending mask each cycle and queues the expected write-stage value.
module tb_arbitro_escrita_banco;
   import arbitro_escrita_banco_pkg::*;

   localparam int N  = 3;
   localparam int LE = 3;
   localparam int LD = 16;

   logic            clock = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*LE-1:0] end_req;
   logic [N*LD-1:0] dado_req;
   logic            bloqueio;
   logic [N-1:0]    ack;
   logic            permisao_escrita;
   logic [LE-1:0]   endereco_regd;
   logic [LD-1:0]   dado_escrita;
   logic [7:0]      pendente;
   logic            ocupado;

   arbitro_escrita_banco #(
      .LARGURA_DADO (LD),
      .LARGURA_END  (LE),
      .N_REQ        (N)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .req              (req),
      .end_req          (end_req),
      .dado_req         (dado_req),
      .bloqueio         (bloqueio),
      .ack              (ack),
      .permisao_escrita (permisao_escrita),
      .endereco_regd    (endereco_regd),
      .dado_escrita     (dado_escrita),
      .pendente         (pendente),
      .ocupado          (ocupado)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic          perm;
      logic [LE-1:0] ende;
      logic [LD-1:0] dado;
   } escrita_t;

   escrita_t      fila[$];
   int            n_assert = 0;
   int            n_fail   = 0;
   int            m_ptr;
   logic          m_perm;
   logic [LE-1:0] m_end;
   logic [LD-1:0] m_dado;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic pedido(input int i, input logic [LE-1:0] a, input logic [LD-1:0] d);
      req[i]             = 1'b1;
      end_req[i*LE +: LE] = a;
      dado_req[i*LD +: LD] = d;
   endtask

   task automatic modelo_reset();
      m_ptr  = 0;
      m_perm = 1'b0;
      m_end  = '0;
      m_dado = '0;
      fila.delete();
   endtask

   // One clock cycle: check combinational outputs against the model, push the
   // expected write stage, then pop and compare it after the edge.
   task automatic passo();
      logic [N-1:0]  g;
      logic [7:0]    pend;
      logic [LE-1:0] a;
      int            w;
      escrita_t      e;
      #1;
      g = '0;
      w = -1;
      if (!bloqueio) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (w < 0 && req[idx]) w = idx;
         end
      end
      if (w >= 0) g[w] = 1'b1;
      pend = '0;
      for (int i = 0; i < N; i++) begin
         a = end_req[i*LE +: LE];
         if (req[i] && a != 0) pend[a] = 1'b1;
      end
      if (m_perm) pend[m_end] = 1'b1;
      check("ack", 32'(ack), 32'(g));
      check("pendente", 32'(pendente), 32'(pend));
      check("ocupado", 32'(ocupado), 32'((|req) | m_perm));
      if (w >= 0) begin
         m_ptr = (w == N - 1) ? 0 : w + 1;
         a     = end_req[w*LE +: LE];
         if (a != 0) begin
            m_perm = 1'b1;
            m_end  = a;
            m_dado = dado_req[w*LD +: LD];
         end else begin
            m_perm = 1'b0;
         end
      end else begin
         m_perm = 1'b0;
      end
      fila.push_back('{perm: m_perm, ende: m_end, dado: m_dado});
      @(posedge clock);
      #1;
      e = fila.pop_front();
      check("permisao_escrita", 32'(permisao_escrita), 32'(e.perm));
      check("endereco_regd", 32'(endereco_regd), 32'(e.ende));
      check("dado_escrita", 32'(dado_escrita), 32'(e.dado));
   endtask

   initial begin
      reset    = 1'b0;
      req      = '0;
      end_req  = '0;
      dado_req = '0;
      bloqueio = 1'b0;
      modelo_reset();

      // Reset held: everything quiet, no grant even with a request present.
      #12;
      check("rst_permisao", 32'(permisao_escrita), 32'd0);
      check("rst_endereco", 32'(endereco_regd), 32'd0);
      check("rst_dado", 32'(dado_escrita), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_pendente", 32'(pendente), 32'd0);
      check("rst_ocupado", 32'(ocupado), 32'd0);
      pedido(REQ_ULA, 3'd3, 16'h00A5);
      #1;
      check("rst_ack_req", 32'(ack), 32'd0);
      @(posedge clock);
      #1;
      check("rst_permisao_req", 32'(permisao_escrita), 32'd0);

      // Single request right after release.
      reset = 1'b1;
      passo();
      req = '0;
      passo();

      // Bring the pointer back to 0, then fairness with all three active.
      pedido(REQ_JAL, 3'd5, 16'h0055);
      passo();
      req = '0;
      pedido(REQ_ULA, 3'd1, 16'h1001);
      pedido(REQ_MEM, 3'd2, 16'h2002);
      pedido(REQ_JAL, REG_LINK, 16'h7007);
      repeat (6) passo();

      // Write to r0 is acknowledged but discarded.
      req = '0;
      pedido(REQ_MEM, REG_ZERO, 16'hFFFF);
      passo();
      req = '0;
      passo();

      // bloqueio freezes grants and the pointer.
      pedido(REQ_ULA, 3'd3, 16'h0303);
      pedido(REQ_MEM, 3'd4, 16'h0404);
      bloqueio = 1'b1;
      repeat (3) passo();
      bloqueio = 1'b0;
      repeat (2) passo();

      // Same target r7 in grant order, starting from pointer 0.
      req = '0;
      pedido(REQ_JAL, 3'd6, 16'h0606);
      passo();
      req = '0;
      pedido(REQ_ULA, REG_LINK, 16'h1111);
      pedido(REQ_JAL, REG_LINK, 16'h2222);
      passo();
      req[REQ_ULA] = 1'b0;
      passo();
      req = '0;
      repeat (2) passo();

      // Reset asserted between the ack edge and the next edge.
      pedido(REQ_ULA, 3'd5, 16'hBEEF);
      passo();
      #1;
      reset = 1'b0;
      #1;
      modelo_reset();
      check("mid_rst_permisao", 32'(permisao_escrita), 32'd0);
      check("mid_rst_endereco", 32'(endereco_regd), 32'd0);
      check("mid_rst_dado", 32'(dado_escrita), 32'd0);
      check("mid_rst_ack", 32'(ack), 32'd0);
      req = '0;
      pedido(REQ_ULA, 3'd1, 16'h0101);
      pedido(REQ_MEM, 3'd2, 16'h0202);
      @(negedge clock);
      reset = 1'b1;
      repeat (2) passo();
      req = '0;
      passo();

      // Random traffic against the model.
      repeat (40) begin
         req      = 3'($urandom_range(0, 7));
         end_req  = 9'($urandom);
         dado_req = 48'({$urandom, $urandom});
         bloqueio = ($urandom_range(0, 3) == 0);
         passo();
      end
      bloqueio = 1'b0;
      req      = '0;
      passo();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
